// File: rtl/pe_pkg.sv
// Shared processing-element definitions: row-position tags carried with IFMap words and feeder FSM states.
package pe_pkg;

  localparam logic [1:0] TAG_MID    = 2'b00;
  localparam logic [1:0] TAG_END    = 2'b01;
  localparam logic [1:0] TAG_START  = 2'b10;
  localparam logic [1:0] TAG_SINGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2
  } feed_state_t;

  // A one-word row is both first and last, so it gets its own tag.
  function automatic logic [1:0] row_tag(input logic is_first, input logic is_last);
    logic [1:0] tag;
    case ({is_first, is_last})
      2'b11:   tag = TAG_SINGLE;
      2'b10:   tag = TAG_START;
      2'b01:   tag = TAG_END;
      default: tag = TAG_MID;
    endcase
    return tag;
  endfunction

endpackage

// File: rtl/ifmap_out_stage.sv
// One-entry valid/ready holding register in front of the IFMap circular buffer.
// Loads on i_load_vld, writes when held and i_buf_rdy; load and write in one cycle keeps it full.
module ifmap_out_stage #(
  parameter int WIDTH = 22
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load_vld,
  input  logic [WIDTH-1:0] i_load_dat,
  input  logic             i_buf_rdy,
  output logic             o_in_rdy,
  output logic             o_out_vld,
  output logic             o_wen,
  output logic [WIDTH-1:0] o_out_dat
);

  logic             r_vld;
  logic [WIDTH-1:0] r_dat;
  logic             w_wen;

  assign w_wen     = r_vld & i_buf_rdy;
  assign o_wen     = w_wen;
  assign o_in_rdy  = ~r_vld | i_buf_rdy;
  assign o_out_vld = r_vld;
  assign o_out_dat = r_dat;

  // Data is only replaced on load, so the output stays stable (never X) while empty.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (i_load_vld) begin
      r_vld <= 1'b1;
      r_dat <= i_load_dat;
    end else if (w_wen) begin
      r_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/ifmap_row_feeder.sv
// Tags raw IFMap words with their row position and writes {tag,data} into the IFMap circular buffer.
// One-cycle latency through a one-entry stage; buf_ready low stalls din_ready without dropping words.
module ifmap_row_feeder
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH    = 20,
  parameter int ROW_LEN_WIDTH = 5,
  parameter int ROWS_WIDTH    = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ROW_LEN_WIDTH-1:0] row_len,
  input  logic [ROWS_WIDTH-1:0]   num_rows,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic                    buf_ready,
  output logic                    buf_wen,
  output logic [DATA_WIDTH+1:0]   buf_din,
  output logic                    busy,
  output logic                    done
);

  localparam logic [ROW_LEN_WIDTH-1:0] RL_ONE = ROW_LEN_WIDTH'(1);
  localparam logic [ROWS_WIDTH-1:0]    RW_ONE = ROWS_WIDTH'(1);

  feed_state_t r_state;
  feed_state_t w_state_nxt;

  logic [ROW_LEN_WIDTH-1:0] r_row_len;
  logic [ROW_LEN_WIDTH-1:0] r_col_cnt;
  logic [ROWS_WIDTH-1:0]    r_num_rows;
  logic [ROWS_WIDTH-1:0]    r_row_cnt;
  logic                     r_empty_done;

  logic                     w_start_ok;
  logic                     w_start_empty;
  logic                     w_stage_rdy;
  logic                     w_out_vld;
  logic                     w_wen;
  logic                     w_accept;
  logic                     w_last_col;
  logic                     w_last_row;
  logic                     w_job_end;
  logic [1:0]               w_tag;
  logic                     w_din_ready;
  logic                     w_busy;
  logic                     w_done;

  assign w_start_ok    = start & (row_len != '0) & (num_rows != '0);
  assign w_start_empty = start & ((row_len == '0) | (num_rows == '0));

  assign w_accept   = din_valid & w_din_ready;
  assign w_last_col = (r_col_cnt == r_row_len - RL_ONE);
  assign w_last_row = (r_row_cnt == r_num_rows - RW_ONE);
  assign w_job_end  = w_accept & w_last_col & w_last_row;
  assign w_tag      = row_tag(r_col_cnt == '0, w_last_col);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_din_ready = 1'b0;
    w_busy      = 1'b0;
    w_done      = r_empty_done;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = ST_FEED;
        end
      end
      ST_FEED: begin
        w_busy      = 1'b1;
        w_din_ready = w_stage_rdy;
        if (w_job_end) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_busy = 1'b1;
        // Job completes on the cycle the last held word lands in the buffer.
        if (w_wen) begin
          w_state_nxt = ST_IDLE;
          w_done      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_row_len    <= '0;
      r_num_rows   <= '0;
      r_col_cnt    <= '0;
      r_row_cnt    <= '0;
      r_empty_done <= 1'b0;
    end else begin
      r_empty_done <= (r_state == ST_IDLE) & w_start_empty;
      if ((r_state == ST_IDLE) && w_start_ok) begin
        r_row_len  <= row_len;
        r_num_rows <= num_rows;
        r_col_cnt  <= '0;
        r_row_cnt  <= '0;
      end else if (w_accept) begin
        if (w_last_col) begin
          r_col_cnt <= '0;
          // Wrap to zero at job end so the row counter never runs past num_rows.
          r_row_cnt <= w_last_row ? '0 : r_row_cnt + RW_ONE;
        end else begin
          r_col_cnt <= r_col_cnt + RL_ONE;
        end
      end
    end
  end

  ifmap_out_stage #(
    .WIDTH(DATA_WIDTH + 2)
  ) u_out_stage (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_load_vld(w_accept),
    .i_load_dat({w_tag, din}),
    .i_buf_rdy (buf_ready),
    .o_in_rdy  (w_stage_rdy),
    .o_out_vld (w_out_vld),
    .o_wen     (w_wen),
    .o_out_dat (buf_din)
  );

  assign buf_wen   = w_wen;
  assign din_ready = w_din_ready;
  assign busy      = w_busy;
  assign done      = w_done;

  // The stage is always loaded while draining, so DRAIN can only exit through a write.
  always_ff @(posedge clk) begin
    if (rst && (r_state == ST_DRAIN)) begin
      assert (w_out_vld);
    end
  end

endmodule

// File: tb/tb_ifmap_row_feeder.sv
module tb_ifmap_row_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  row_len;
  logic [4:0]  num_rows;
  logic [19:0] din;
  logic        din_valid;
  logic        din_ready;
  logic        buf_ready;
  logic        buf_wen;
  logic [21:0] buf_din;
  logic        busy;
  logic        done;

  always #19 clk = ~clk;

  ifmap_row_feeder #(
    .DATA_WIDTH(20),
    .ROW_LEN_WIDTH(5),
    .ROWS_WIDTH(5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .row_len  (row_len),
    .num_rows (num_rows),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .buf_ready(buf_ready),
    .buf_wen  (buf_wen),
    .buf_din  (buf_din),
    .busy     (busy),
    .done     (done)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [19:0] src_q[$];
  logic [21:0] wr_q[$];
  int src_idx, acc_cnt, done_cnt, busy_cnt;
  logic last_wen, last_done, last_busy, last_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs on the falling edge, then return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    last_wen  = buf_wen;
    last_done = done;
    last_busy = busy;
    last_rdy  = din_ready;
    if (buf_wen) wr_q.push_back(buf_din);
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (din_valid && din_ready) begin
      src_idx++;
      acc_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  // Reference: word i of the job sits at column i%rl of its row.
  function automatic logic [21:0] model_word(input int i, input int rl);
    logic [1:0] tag;
    int col;
    col = i % rl;
    if (rl == 1)           tag = 2'b11;
    else if (col == 0)     tag = 2'b10;
    else if (col == rl-1)  tag = 2'b01;
    else                   tag = 2'b00;
    return {tag, src_q[i]};
  endfunction

  task automatic fill_random(input int n);
    src_q.delete();
    for (int i = 0; i < n; i++) src_q.push_back(20'($urandom));
  endtask

  // vmode: 0 always valid, 1 alternating, 2 random. rmode: 0 ready, 1 random, 2 stall 5 cycles after 2nd accept.
  task automatic run_job(input int rl, input int nr, input int vmode, input int rmode,
                         input bit spam, input string name);
    int budget;
    int cyc;
    int stall;
    int exp_n;
    bit stalling;
    budget = 3000;
    cyc    = 0;
    stall  = 0;
    exp_n  = rl * nr;
    wr_q.delete();
    src_idx = 0; acc_cnt = 0; done_cnt = 0; busy_cnt = 0;
    start = 1'b1; row_len = 5'(rl); num_rows = 5'(nr); din_valid = 1'b0; buf_ready = 1'b1;
    tick();
    start = 1'b0;
    while (done_cnt == 0 && cyc < budget) begin
      din = (src_idx < src_q.size()) ? src_q[src_idx] : 20'h0;
      case (vmode)
        0:       din_valid = (src_idx < src_q.size());
        1:       din_valid = (cyc % 2 == 0) && (src_idx < src_q.size());
        default: din_valid = ($urandom_range(0, 1) == 1) && (src_idx < src_q.size());
      endcase
      stalling = 1'b0;
      if (rmode == 2 && acc_cnt >= 2 && stall < 5) begin
        buf_ready = 1'b0;
        stall++;
        stalling = 1'b1;
      end else if (rmode == 1) begin
        buf_ready = ($urandom_range(0, 3) != 0);
      end else begin
        buf_ready = 1'b1;
      end
      if (spam) begin
        start    = ($urandom_range(0, 1) == 1);
        row_len  = 5'($urandom_range(1, 31));
        num_rows = 5'($urandom_range(1, 31));
      end
      tick();
      cyc++;
      if (stalling) chk({name, "_stall_rdy"}, 32'(last_rdy), 32'd0);
    end
    start = 1'b0; din_valid = 1'b0; buf_ready = 1'b1;
    chk({name, "_timeout"}, 32'(cyc < budget), 32'd1);
    tick();
    chk({name, "_busy_after"}, 32'(last_busy), 32'd0);
    repeat (3) tick();
    chk({name, "_nwrites"}, 32'(wr_q.size()), 32'(exp_n));
    chk({name, "_ndone"}, 32'(done_cnt), 32'd1);
    for (int i = 0; i < exp_n; i++) begin
      chk({name, "_word"}, (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hffff_ffff, 32'(model_word(i, rl)));
    end
    if (vmode == 0 && rmode == 0 && !spam) chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_n + 1));
  endtask

  initial begin
    #(38 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; row_len = '0; num_rows = '0;
    din = '0; din_valid = 1'b0; buf_ready = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_din_ready", 32'(din_ready), 32'd0);
    chk("rst_buf_wen", 32'(buf_wen), 32'd0);
    chk("rst_buf_din", 32'(buf_din), 32'd0);
    rst = 1'b1;
    tick();

    src_q = '{20'(161), 20'(190), 20'(-161), 20'(-81), 20'(50), 20'(-80)};
    run_job(3, 2, 0, 0, 1'b0, "t1");

    src_q = '{20'(5), 20'(6), 20'(7)};
    run_job(1, 3, 0, 0, 1'b0, "t2");

    fill_random(4);
    run_job(4, 1, 0, 2, 1'b0, "t3");

    fill_random(4);
    run_job(2, 2, 1, 0, 1'b0, "t4");

    // Empty jobs: done one cycle later, no writes, never busy.
    for (int k = 0; k < 2; k++) begin
      wr_q.delete(); done_cnt = 0;
      start = 1'b1; row_len = (k == 0) ? 5'd3 : 5'd0; num_rows = (k == 0) ? 5'd0 : 5'd2;
      tick();
      chk("t5_done_early", 32'(last_done), 32'd0);
      start = 1'b0;
      tick();
      chk("t5_done", 32'(last_done), 32'd1);
      chk("t5_busy", 32'(last_busy), 32'd0);
      tick();
      chk("t5_done_once", 32'(last_done), 32'd0);
      chk("t5_nwrites", 32'(wr_q.size()), 32'd0);
    end

    fill_random(4);
    run_job(2, 2, 0, 0, 1'b1, "t5_spam");

    // Reset in the middle of a job.
    fill_random(6);
    wr_q.delete(); src_idx = 0; acc_cnt = 0;
    start = 1'b1; row_len = 5'd3; num_rows = 5'd2;
    tick();
    start = 1'b0;
    for (int c = 0; c < 50 && acc_cnt < 3; c++) begin
      din = src_q[src_idx];
      din_valid = 1'b1;
      tick();
    end
    chk("t6_accepts", 32'(acc_cnt), 32'd3);
    rst = 1'b0; din_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("t6_busy", 32'(last_busy), 32'd0);
    chk("t6_wen", 32'(last_wen), 32'd0);
    fill_random(2);
    run_job(2, 1, 0, 0, 1'b0, "t6");

    for (int t = 0; t < 6; t++) begin
      int rl;
      int nr;
      rl = $urandom_range(1, 6);
      nr = $urandom_range(1, 4);
      fill_random(rl * nr);
      run_job(rl, nr, 2, 1, 1'b0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
